// File: rtl/radix_stage_sched_if.sv
// radix_stage_sched_if: butterfly-side inputs and read-schedule outputs of one
// radix-2 SDF stage read sequencer. The master modport is the sequencer itself;
// the slave modport is the surrounding stage (FIFO, twiddle provider, sink).
interface radix_stage_sched_if #(
  parameter int ADDR_W = 9
);
  logic              bf_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              out_ready;
  logic              rd_en;
  logic              tf_en;
  logic [ADDR_W-1:0] tf_addr;
  logic              busy;
  logic              frame_done;
  logic [1:0]        pending;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    input  bf_valid, fifo_full, fifo_empty, out_ready,
    output rd_en, tf_en, tf_addr, busy, frame_done, pending,
    output overflow_err, underflow_err
  );

  modport slave (
    output bf_valid, fifo_full, fifo_empty, out_ready,
    input  rd_en, tf_en, tf_addr, busy, frame_done, pending,
    input  overflow_err, underflow_err
  );
endinterface

// File: rtl/radix_stage_sched.sv
// radix_stage_sched: read-side sequencer for one radix-2 single-path-delay stage.
// Counts y2 writes into the stage FIFO and, after each complete half-frame,
// issues a gap-free HALF_LEN-long read burst with a lockstep twiddle address.
// Up to two completed bursts are queued; back-to-back bursts drain with no bubble.
// Optional downstream back-pressure: define RADIX_STAGE_SCHED_STALL_EN to gate
// each read with out_ready (otherwise out_ready is ignored).
module radix_stage_sched #(
  parameter int HALF_LEN = 512,
  parameter int ADDR_W   = 9,
  parameter int TF_STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  radix_stage_sched_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(HALF_LEN - 1);
  localparam logic [ADDR_W-1:0] TF_STEP_W = ADDR_W'(TF_STEP);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // Twiddle index: low ADDR_W bits of the product depend only on the low
  // ADDR_W bits of the operands, so a native-width multiply is the modulo.
  function automatic logic [ADDR_W-1:0] tf_index(input logic [ADDR_W-1:0] cnt);
    return cnt * TF_STEP_W;
  endfunction

  // Pending-burst counter update, saturating at 2 and never going below 0.
  function automatic logic [1:0] sat_pending(input logic [1:0] p,
                                             input logic       inc,
                                             input logic       dec);
    if (inc && !dec) return (p == 2'd2) ? 2'd2 : p + 2'd1;
    if (dec && !inc) return (p == 2'd0) ? 2'd0 : p - 2'd1;
    return p;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] w_rd_cnt_nxt;
  logic [1:0]        r_pending;
  logic [1:0]        w_pending_nxt;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_tf_addr;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_ovf;
  logic              r_unf;
  logic              w_ready;
  logic              w_wr_done;
  logic              w_rd_last;
  logic              w_sat_ovf;
  logic              w_full_ovf;

`ifdef RADIX_STAGE_SCHED_STALL_EN
  assign w_ready = bus.out_ready;
`else
  logic w_unused_out_ready;
  assign w_ready            = 1'b1;
  assign w_unused_out_ready = bus.out_ready;
`endif

  // A read happens in every cycle where the registered rd_en is high, so the
  // burst ends on the cycle carrying read index HALF_LEN-1.
  assign w_wr_done  = bus.bf_valid && (r_wr_cnt == LAST_IDX);
  assign w_rd_last  = r_rd_en && (r_rd_cnt == LAST_IDX);
  assign w_sat_ovf  = w_wr_done && !w_rd_last && (r_pending == 2'd2);
  assign w_full_ovf = bus.bf_valid && bus.fifo_full && !r_rd_en;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, next read index and pending update.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_pending_nxt = sat_pending(r_pending, w_wr_done, w_rd_last);
    unique case (r_state)
      S_IDLE: begin
        if ((r_pending != 2'd0) || w_wr_done) begin
          w_state_nxt  = S_DRAIN;
          w_rd_cnt_nxt = '0;
        end
      end
      S_DRAIN: begin
        if (w_rd_last) begin
          w_rd_cnt_nxt = '0;
          if (w_pending_nxt == 2'd0) w_state_nxt = S_IDLE;
        end else if (r_rd_en) begin
          w_rd_cnt_nxt = r_rd_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_rd_cnt_nxt = '0;
      end
    endcase
  end

  // Counters, registered outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_pending    <= 2'd0;
      r_rd_en      <= 1'b0;
      r_tf_addr    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      if (bus.bf_valid) r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + ADDR_W'(1);
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_rd_en      <= (w_state_nxt == S_DRAIN) && w_ready;
      r_tf_addr    <= tf_index(w_rd_cnt_nxt);
      r_busy       <= (w_state_nxt == S_DRAIN);
      r_frame_done <= w_rd_last;
      r_ovf        <= r_ovf | w_sat_ovf | w_full_ovf;
      r_unf        <= r_unf | (r_rd_en && bus.fifo_empty);
    end
  end

  assign bus.rd_en         = r_rd_en;
  assign bus.tf_en         = r_rd_en;
  assign bus.tf_addr       = r_tf_addr;
  assign bus.busy          = r_busy;
  assign bus.frame_done    = r_frame_done;
  assign bus.pending       = r_pending;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;

endmodule

// File: tb/tb_radix_stage_sched.sv
// tb_radix_stage_sched: scenario tasks for the radix-2 stage read sequencer,
// compared cycle by cycle against an integer reference model of the schedule
// and against fixed burst timing expectations.
`timescale 1ns/1ps
module tb_radix_stage_sched;
  localparam int HL     = 512;
  localparam int AW     = 9;
  localparam int STEP   = 1;
  localparam int HL_B   = 128;
  localparam int STEP_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix_stage_sched_if #(.ADDR_W(AW)) bus ();
  radix_stage_sched_if #(.ADDR_W(AW)) bus_b ();

  radix_stage_sched #(.HALF_LEN(HL), .ADDR_W(AW), .TF_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  radix_stage_sched #(.HALF_LEN(HL_B), .ADDR_W(AW), .TF_STEP(STEP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: writes in current half-frame, queued bursts,
  // whether a drain is running and which read index comes next.
  int m_wr, m_pend, m_idx, m_tf;
  bit m_reading, m_rd_en, m_busy, m_fd, m_ovf, m_unf;

  task automatic model_edge();
    bit done, last, rdy;
    int newp;
    if (rst) begin
      m_wr = 0; m_pend = 0; m_idx = 0; m_tf = 0;
      m_reading = 0; m_rd_en = 0; m_busy = 0; m_fd = 0; m_ovf = 0; m_unf = 0;
    end else begin
`ifdef RADIX_STAGE_SCHED_STALL_EN
      rdy = bus.out_ready;
`else
      rdy = 1'b1;
`endif
      done = bus.bf_valid && (m_wr == HL - 1);
      last = m_rd_en && (m_idx == HL - 1);
      if (bus.bf_valid) m_wr = done ? 0 : m_wr + 1;
      if (m_rd_en && bus.fifo_empty) m_unf = 1;
      if (bus.bf_valid && bus.fifo_full && !m_rd_en) m_ovf = 1;
      newp = m_pend + int'(done) - int'(last);
      if (newp > 2) begin newp = 2; m_ovf = 1; end
      if (!m_reading) begin
        if (m_pend > 0 || done) begin m_reading = 1; m_idx = 0; end
      end else if (last) begin
        m_idx = 0;
        if (newp == 0) m_reading = 0;
      end else if (m_rd_en) begin
        m_idx++;
      end
      m_pend  = newp;
      m_fd    = last;
      m_busy  = m_reading;
      m_rd_en = m_reading && rdy;
      m_tf    = (m_idx * STEP) % (1 << AW);
    end
  endtask

  function automatic logic [AW+7:0] model_vec();
    return {m_rd_en, m_rd_en, m_busy, m_fd, 2'(m_pend), m_ovf, m_unf, AW'(m_tf)};
  endfunction

  function automatic logic [AW+7:0] dut_vec();
    return {bus.rd_en, bus.tf_en, bus.busy, bus.frame_done, bus.pending,
            bus.overflow_err, bus.underflow_err, bus.tf_addr};
  endfunction

  // One clock: model follows the inputs seen at the rising edge; the caller
  // samples the DUT on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.bf_valid   = 1'b0; bus.fifo_full   = 1'b0; bus.fifo_empty   = 1'b0; bus.out_ready   = 1'b1;
    bus_b.bf_valid = 1'b0; bus_b.fifo_full = 1'b0; bus_b.fifo_empty = 1'b0; bus_b.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h expected 0", dut_vec());
    end
    n_checks++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_model got %h expected %h", dut_vec(), model_vec());
    end
    n_checks++;
    if ({bus_b.rd_en, bus_b.pending, bus_b.tf_addr} !== '0) begin
      n_fail++; $display("FAIL reset_b got %h expected 0", {bus_b.rd_en, bus_b.pending, bus_b.tf_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    int reads;
    reads = 0;
    for (int t = 0; t < 2*HL + 4; t++) begin
      bus.bf_valid = (t < HL);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL single_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
      n_checks++;
      if (bus.rd_en !== ((t >= HL-1) && (t < 2*HL-1))) begin
        n_fail++; $display("FAIL single_rd_en t=%0d got %b", t, bus.rd_en);
      end
      n_checks++;
      if (bus.pending !== (((t >= HL-1) && (t < 2*HL-1)) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL single_pending t=%0d got %0d", t, bus.pending);
      end
      n_checks++;
      if (bus.frame_done !== (t == 2*HL-1)) begin
        n_fail++; $display("FAIL single_frame_done t=%0d got %b", t, bus.frame_done);
      end
      n_checks++;
      if (bus.busy !== bus.rd_en) begin
        n_fail++; $display("FAIL single_busy t=%0d got %b expected %b", t, bus.busy, bus.rd_en);
      end
      if (bus.rd_en === 1'b1) begin
        n_checks++;
        if (bus.tf_addr !== AW'(reads)) begin
          n_fail++; $display("FAIL single_tf_addr t=%0d got %0d expected %0d", t, bus.tf_addr, reads);
        end
        reads++;
      end
    end
    n_checks++;
    if (reads != HL) begin
      n_fail++; $display("FAIL single_read_count got %0d expected %0d", reads, HL);
    end
  endtask

  task automatic test_back_to_back();
    int reads;
    reads = 0;
    for (int t = 0; t < 3*HL + 4; t++) begin
      bus.bf_valid = (t < 2*HL);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL b2b_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
      n_checks++;
      if (bus.rd_en !== ((t >= HL-1) && (t < 3*HL-1))) begin
        n_fail++; $display("FAIL b2b_rd_en t=%0d got %b", t, bus.rd_en);
      end
      n_checks++;
      if (bus.pending !== (((t >= HL-1) && (t < 3*HL-1)) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL b2b_pending t=%0d got %0d expected 1 in drain", t, bus.pending);
      end
      n_checks++;
      if (bus.frame_done !== ((t == 2*HL-1) || (t == 3*HL-1))) begin
        n_fail++; $display("FAIL b2b_frame_done t=%0d got %b", t, bus.frame_done);
      end
      if (bus.rd_en === 1'b1) begin
        n_checks++;
        if (bus.tf_addr !== AW'(reads % HL)) begin
          n_fail++; $display("FAIL b2b_tf_addr t=%0d got %0d expected %0d", t, bus.tf_addr, reads % HL);
        end
        reads++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int t = 0; t <= HL - 1 + 200; t++) begin
      bus.bf_valid = (t < HL);
      tick();
    end
    n_checks++;
    if (bus.tf_addr !== AW'(200) || bus.rd_en !== 1'b1) begin
      n_fail++; $display("FAIL mid_at_read200 got addr %0d rd_en %b expected 200 1", bus.tf_addr, bus.rd_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.rd_en, bus.pending, bus.frame_done, bus.busy} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_abort got %b expected 00000",
                         {bus.rd_en, bus.pending, bus.frame_done, bus.busy});
    end
    test_single_burst();
  endtask

  task automatic test_errors();
    do_reset();
    for (int t = 0; t < 2*HL + 2; t++) begin
      bus.bf_valid   = (t < HL);
      bus.fifo_empty = (t >= HL + 10) && (t < HL + 13);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL err_unf_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
    end
    n_checks++;
    if ({bus.underflow_err, bus.overflow_err} !== 2'b10) begin
      n_fail++; $display("FAIL err_underflow_sticky got unf=%b ovf=%b expected 1 0", bus.underflow_err, bus.overflow_err);
    end
    do_reset();
    n_checks++;
    if (bus.underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL err_underflow_clear got %b expected 0", bus.underflow_err);
    end
    bus.fifo_full = 1'b1;
    for (int t = 0; t < 3*HL; t++) begin
      bus.bf_valid = 1'b1;
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL err_ovf_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
    end
    drive_idle();
    tick();
    n_checks++;
    if (bus.overflow_err !== 1'b1) begin
      n_fail++; $display("FAIL err_overflow got %b expected 1", bus.overflow_err);
    end
    do_reset();
    n_checks++;
    if (bus.overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL err_overflow_clear got %b expected 0", bus.overflow_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      bus.bf_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 1) != 0);
      bus.fifo_full  = ($urandom_range(0, 299) == 0);
      bus.fifo_empty = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
    end
    drive_idle();
    do_reset();
  endtask

  task automatic test_tf_step4();
    int reads;
    reads = 0;
    do_reset();
    for (int t = 0; t < 2*HL_B + 4; t++) begin
      bus_b.bf_valid = (t < HL_B);
      tick();
      n_checks++;
      if (bus_b.rd_en !== ((t >= HL_B-1) && (t < 2*HL_B-1))) begin
        n_fail++; $display("FAIL step4_rd_en t=%0d got %b", t, bus_b.rd_en);
      end
      n_checks++;
      if (bus_b.frame_done !== (t == 2*HL_B-1)) begin
        n_fail++; $display("FAIL step4_frame_done t=%0d got %b", t, bus_b.frame_done);
      end
      if (bus_b.rd_en === 1'b1) begin
        n_checks++;
        if (bus_b.tf_addr !== AW'((reads * STEP_B) % 512)) begin
          n_fail++; $display("FAIL step4_tf_addr t=%0d got %0d expected %0d", t, bus_b.tf_addr, (reads * STEP_B) % 512);
        end
        reads++;
      end
    end
    n_checks++;
    if (reads != HL_B) begin
      n_fail++; $display("FAIL step4_read_count got %0d expected %0d", reads, HL_B);
    end
  endtask

`ifdef RADIX_STAGE_SCHED_STALL_EN
  task automatic test_stall();
    int reads;
    reads = 0;
    do_reset();
    for (int t = 0; t < 2*HL + 16; t++) begin
      bus.bf_valid  = (t < HL);
      bus.out_ready = !((t >= HL - 1 + 100) && (t < HL - 1 + 110));
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL stall_model t=%0d got %h expected %h", t, dut_vec(), model_vec());
      end
      if ((t >= HL + 99) && (t < HL + 109)) begin
        n_checks++;
        if (bus.rd_en !== 1'b0 || bus.tf_addr !== AW'(100)) begin
          n_fail++; $display("FAIL stall_hold t=%0d got rd_en %b addr %0d expected 0 100", t, bus.rd_en, bus.tf_addr);
        end
      end
      n_checks++;
      if (bus.frame_done !== (t == 2*HL - 1 + 10)) begin
        n_fail++; $display("FAIL stall_frame_done t=%0d got %b", t, bus.frame_done);
      end
      if (bus.rd_en === 1'b1) reads++;
    end
    n_checks++;
    if (reads != HL) begin
      n_fail++; $display("FAIL stall_read_count got %0d expected %0d", reads, HL);
    end
    drive_idle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_errors();
    test_tf_step4();
`ifdef RADIX_STAGE_SCHED_STALL_EN
    test_stall();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
